counter_uart_reporter: RTL and testbench

COUNTER_UART_REPORTER -- requirements
Module: counter_uart_reporter

---
 rtl/counter_uart_pkg.sv | 45 ++++
 rtl/counter_uart_reporter_tx.sv | 93 +++++++++
 rtl/counter_uart_reporter.sv | 81 ++++++++
 tb/tb_counter_uart_reporter.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_uart_pkg.sv
// counter_uart_pkg
// Shared definitions for the counter UART reporter: FSM state encoding,
// ASCII constants, the default bit period and the report byte helpers.
// No ports.
package counter_uart_pkg;

   // 12 MHz system clock / 115200 baud.
   localparam int DEFAULT_CLKS_PER_BIT = 104;

   // Bytes per report frame: hex high, hex low, CR, LF.
   localparam int NUM_BYTES = 4;

   localparam logic [7:0] ASCII_CR      = 8'h0D;
   localparam logic [7:0] ASCII_LF      = 8'h0A;
   localparam logic [7:0] ASCII_ZERO    = 8'h30;
   localparam logic [7:0] ASCII_UPPER_A = 8'h41;

   // NEXT is a decision point at the end of a stop bit; it resolves in the
   // same cycle, so it never occupies a bit-time of its own.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      NEXT  = 3'd4
   } state_t;

   // Nibble to uppercase hex ASCII.
   function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
      if (nibble < 4'd10) return ASCII_ZERO + {4'd0, nibble};
      else                return ASCII_UPPER_A + {4'd0, nibble} - 8'd10;
   endfunction

   // Byte number idx of the report frame for a given value.
   function automatic logic [7:0] report_byte(input logic [1:0] idx,
                                              input logic [7:0] value);
      case (idx)
         2'd0:    return hex_ascii(value[7:4]);
         2'd1:    return hex_ascii(value[3:0]);
         2'd2:    return ASCII_CR;
         default: return ASCII_LF;
      endcase
   endfunction

endpackage

// File: rtl/counter_uart_reporter_tx.sv
// uart_tx_byte
// Serialises one byte as 8N1, LSB first, with a registered tx line.
// A start strobe is accepted while idle or in the last cycle of a stop bit,
// so back-to-back bytes leave no idle gap on the line.
// Ports:
//   CLK   - system clock
//   RST   - asynchronous active-high reset
//   start - load data and begin a byte (honoured when idle or on done)
//   data  - byte to send, sampled with start
//   tx    - UART line, idle high
//   done  - high during the last cycle of the stop bit
module uart_tx_byte
   import counter_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       done
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   state_t           state;
   state_t           state_next;
   logic [CNT_W-1:0] bit_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;
   logic             tx_next;
   logic             bit_end;
   logic             load;

   assign bit_end = (bit_cnt == CNT_LAST);
   assign done    = (state == STOP) && bit_end;
   assign load    = start && ((state == IDLE) || done);

   always_comb begin
      // NOTE: every combinational output gets a default first so that no
      // path through the case leaves it unassigned and infers a latch.
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = START;
         START:   if (bit_end) state_next = DATA;
         DATA:    if (bit_end && (bit_idx == 3'd7)) state_next = STOP;
         STOP:    if (bit_end) state_next = NEXT;
         default: state_next = IDLE;
      endcase
      // Resolve NEXT immediately: another byte goes straight to its start
      // bit, otherwise the line returns to idle.
      if (state_next == NEXT) state_next = start ? START : IDLE;
   end

   // tx is registered, so compute the level for the coming cycle. On the
   // last cycle of a data bit the shift register moves at the same edge,
   // hence the next bit is shreg[1].
   always_comb begin
      tx_next = 1'b1;
      case (state_next)
         START:   tx_next = 1'b0;
         DATA:    tx_next = ((state == DATA) && bit_end) ? shreg[1] : shreg[0];
         default: tx_next = 1'b1;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= IDLE;
         bit_cnt <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         tx      <= 1'b1;
      end else begin
         state <= state_next;
         tx    <= tx_next;

         if ((state == IDLE) || bit_end) bit_cnt <= '0;
         else                            bit_cnt <= bit_cnt + CNT_W'(1);

         if (load)                             shreg <= data;
         else if ((state == DATA) && bit_end)  shreg <= {1'b0, shreg[7:1]};

         // Wraps 7 -> 0 at the end of the last data bit, ready for the next byte.
         if ((state == DATA) && bit_end) bit_idx <= bit_idx + 3'd1;
      end
   end

endmodule

// File: rtl/counter_uart_reporter.sv
// counter_uart_reporter
// Reports an 8-bit counter value over UART as "HH\r\n" on every accepted
// tick. Ticks arriving while a report is in progress are counted in a
// saturating dropped counter and otherwise ignored.
// Ports:
//   CLK     - system clock, all state changes on its rising edge
//   RST     - asynchronous active-high reset
//   tick    - single-cycle report request
//   counter - value to report, snapshotted when tick is accepted
//   tx      - UART line, 8N1, LSB first, idle high
//   busy    - high while a report frame is in progress
//   dropped - number of ticks ignored while busy, saturating at 255
module counter_uart_reporter
   import counter_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       tick,
   input  logic [7:0] counter,
   output logic       tx,
   output logic       busy,
   output logic [7:0] dropped
);

   logic [7:0] snapshot;
   logic [1:0] byte_idx;
   logic       accept;
   logic       last_byte;
   logic       byte_done;
   logic       byte_start;
   logic [7:0] byte_data;

   // busy is low exactly when the serialiser is idle, so it doubles as the
   // "FSM in IDLE" qualifier for accepting a tick.
   assign accept     = tick && !busy;
   assign last_byte  = (byte_idx == 2'(NUM_BYTES - 1));
   assign byte_start = accept || (byte_done && !last_byte);

   // The first byte comes straight from the input because the snapshot is
   // only written on the accepting edge; later bytes come from the snapshot.
   assign byte_data = accept ? hex_ascii(counter[7:4])
                             : report_byte(byte_idx + 2'd1, snapshot);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         snapshot <= '0;
         byte_idx <= '0;
         busy     <= 1'b0;
         dropped  <= '0;
      end else begin
         if (accept) begin
            snapshot <= counter;
            byte_idx <= '0;
            busy     <= 1'b1;
         end else if (byte_done) begin
            if (last_byte) begin
               busy     <= 1'b0;
               byte_idx <= '0;
            end else begin
               byte_idx <= byte_idx + 2'd1;
            end
         end

         if (tick && busy && (dropped != 8'hFF)) dropped <= dropped + 8'd1;
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_tx (
      .CLK  (CLK),
      .RST  (RST),
      .start(byte_start),
      .data (byte_data),
      .tx   (tx),
      .done (byte_done)
   );

endmodule

// File: tb/tb_counter_uart_reporter.sv
// tb_counter_uart_reporter
// Directed bench for counter_uart_reporter with CLKS_PER_BIT = 4. Expected
// bytes are queued when a tick is driven; a line monitor decodes tx and
// compares each received byte against the head of the queue.
module tb_counter_uart_reporter;

   localparam int CPB   = 4;
   localparam int FRAME = 40 * CPB;
   localparam int SLOTS = 10 * CPB;

   logic       CLK = 1'b0;
   logic       RST = 1'b0;
   logic       tick = 1'b0;
   logic [7:0] counter = 8'h00;
   logic       tx;
   logic       busy;
   logic [7:0] dropped;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];

   always #5 CLK = ~CLK;

   counter_uart_reporter #(
      .CLKS_PER_BIT(CPB)
   ) dut (
      .CLK    (CLK),
      .RST    (RST),
      .tick   (tick),
      .counter(counter),
      .tx     (tx),
      .busy   (busy),
      .dropped(dropped)
   );

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic push_frame(input logic [7:0] hi, input logic [7:0] lo);
      exp_q.push_back(hi);
      exp_q.push_back(lo);
      exp_q.push_back(8'h0D);
      exp_q.push_back(8'h0A);
   endtask

   // Called on the negedge of the first frame cycle; counts busy cycles up to
   // the first idle cycle and confirms every queued byte was received.
   task automatic wait_frame_end(input string tag, input int exp_cycles);
      int n;
      n = 0;
      while ((busy === 1'b1) && (n < 2000)) begin
         n++;
         @(negedge CLK);
      end
      check({tag, "_busy_cycles"}, n, exp_cycles);
      check({tag, "_queue_drained"}, exp_q.size(), 0);
   endtask

   // Drives a tick for one cycle starting at the current negedge and checks
   // the start bit appears in the very next cycle.
   task automatic accepted_tick(input string tag, input logic [7:0] value);
      counter = value;
      tick    = 1'b1;
      @(negedge CLK);
      tick = 1'b0;
      check({tag, "_tx_start_latency"}, tx, 0);
      check({tag, "_busy_set"}, busy, 1);
   endtask

   // Line monitor: one sample per cycle on the falling edge.
   initial begin : monitor
      logic [SLOTS-1:0] s;
      logic             aborted;
      logic             stable;
      logic [7:0]       got;
      logic [7:0]       exp;
      forever begin
         @(negedge CLK);
         if (!RST && (tx === 1'b0)) begin
            s       = '0;
            s[0]    = tx;
            aborted = 1'b0;
            for (int k = 1; k < SLOTS; k++) begin
               @(negedge CLK);
               if (RST) begin
                  aborted = 1'b1;
                  break;
               end
               s[k] = tx;
            end
            if (!aborted) begin
               stable = 1'b1;
               for (int j = 0; j < 10; j++)
                  for (int m = 1; m < CPB; m++)
                     if (s[j*CPB+m] !== s[j*CPB]) stable = 1'b0;
               for (int j = 0; j < 8; j++) got[j] = s[(j+1)*CPB];
               check("bit_stable", stable, 1);
               check("start_bit_low", s[0], 0);
               check("stop_bit_high", s[9*CPB], 1);
               check("byte_was_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  exp = exp_q.pop_front();
                  check("byte_value", got, exp);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      int  n_drop;
      int  guard;
      int  n;
      logic all_high;

      // Reset state.
      #1 RST = 1'b1;
      repeat (3) @(negedge CLK);
      check("reset_tx", tx, 1);
      check("reset_busy", busy, 0);
      check("reset_dropped", dropped, 0);
      RST = 1'b0;
      repeat (3) @(negedge CLK);
      check("idle_tx", tx, 1);

      // 0x3A -> "3A\r\n", 160-cycle frame.
      push_frame(8'h33, 8'h41);
      accepted_tick("f3a", 8'h3A);
      wait_frame_end("f3a", FRAME);

      // Tick in the first idle cycle, counter changed right after acceptance.
      push_frame(8'h30, 8'h39);
      counter = 8'h09;
      tick    = 1'b1;
      @(negedge CLK);
      tick    = 1'b0;
      counter = 8'h00;
      check("f09_tx_start_latency", tx, 0);
      check("f09_busy_set", busy, 1);
      check("f09_dropped_unchanged", dropped, 0);
      wait_frame_end("f09", FRAME);

      // Dropped ticks: one at 50 cycles into a frame, then up to 300 total.
      push_frame(8'h41, 8'h35);
      accepted_tick("fa5", 8'hA5);
      repeat (49) @(negedge CLK);
      counter = 8'h77;
      tick    = 1'b1;
      @(negedge CLK);
      tick = 1'b0;
      check("drop_first", dropped, 1);
      n_drop = 1;
      guard  = 0;
      while ((n_drop < 300) && (guard < 5000)) begin
         tick = 1'b1;
         if (busy) begin
            counter = 8'($urandom_range(0, 255));
            n_drop++;
         end else begin
            counter = 8'h5C;
            push_frame(8'h35, 8'h43);
         end
         @(negedge CLK);
         guard++;
      end
      tick = 1'b0;
      check("drop_loop_bounded", n_drop, 300);
      n = 0;
      while ((busy === 1'b1) && (n < 2000)) begin
         n++;
         @(negedge CLK);
      end
      check("drop_final_idle", busy, 0);
      check("drop_saturated", dropped, 255);
      check("drop_queue_drained", exp_q.size(), 0);

      // Reset during byte 2 of a frame.
      push_frame(8'h31, 8'h32);
      accepted_tick("f12", 8'h12);
      repeat (85) @(negedge CLK);
      #1 RST = 1'b1;
      #1;
      check("rst_mid_tx", tx, 1);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_dropped", dropped, 0);
      exp_q.delete();
      repeat (2) @(negedge CLK);
      RST      = 1'b0;
      all_high = 1'b1;
      repeat (10) begin
         @(negedge CLK);
         if (tx !== 1'b1) all_high = 1'b0;
      end
      check("post_rst_line_idle", all_high, 1);
      check("post_rst_busy", busy, 0);

      // Fresh frame after reset: 0xF0 -> "F0\r\n".
      push_frame(8'h46, 8'h30);
      accepted_tick("ff0", 8'hF0);
      wait_frame_end("ff0", FRAME);
      check("final_dropped", dropped, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
